qpsk_bit_combiner: RTL and testbench
====================================

// Module: qpsk_bit_combiner
// PURPOSE
//  Receive-side inverse of the QPSK transmit bit splitter: takes demapped 2-bit symbols
//  (sym_in[1]=I bit, sym_in[0]=Q bit) and re-serialises them into the original bitstream.
//  Sits between the QPSK demapper/slicer and the serial data sink. Valid/ready on both sides.
//  A small symbol FIFO absorbs sink stalls.
// PARAMETERS
//  FIFO_DEPTH  4  symbol FIFO entries; power of 2, >=2
//  I_FIRST     1  1: I bit (sym_in[1]) is sent first; 0: Q bit first
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  clr         in   1   synchronous flush of FIFO and serialiser
//  sym_in      in   2   demapped symbol {I,Q}
//  sym_valid   in   1   sym_in valid
//  sym_ready   out  1   block can accept a symbol
//  bit_out     out  1   serial data bit
//  bit_valid   out  1   bit_out valid
//  bit_ready   in   1   sink accepts bit_out
//  fifo_level  out  $clog2(FIFO_DEPTH+1)  symbols currently buffered (excl. serialiser)
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO empty, fifo_level=0, state IDLE, bit_valid=0, bit_out=0,
//   sym_ready=0 while in reset, 1 from first edge after deassertion.
//  Push: sym_valid&&sym_ready at rising edge writes sym_in. sym_ready = (fifo_level!=FIFO_DEPTH).
//   No bypass when full: a simultaneous pop does not make sym_ready high in that cycle.
//  Serialiser FSM, 2-bit shift register sh[1:0]:
//   IDLE   : bit_valid=0. FIFO non-empty -> pop into sh, go FIRST.
//   FIRST  : bit_out = I_FIRST ? sh[1] : sh[0]; bit_valid=1. bit_ready -> SECOND; else hold.
//   SECOND : bit_out = other bit; bit_valid=1. bit_ready & FIFO non-empty -> pop, FIRST;
//            bit_ready & FIFO empty -> IDLE; !bit_ready -> hold.
//  bit_out/bit_valid are registered; bit_out stable while bit_valid&&!bit_ready.
//  Latency: symbol pushed at edge N into empty FIFO/IDLE -> popped at edge N+1 ->
//   first bit valid after edge N+1, second bit after the first accepted handshake.
//  Throughput: 1 bit/clk sustained (2 clks/symbol) with bit_ready=1 and non-empty FIFO.
//  Simultaneous push and pop: fifo_level unchanged; pointers both advance; wrap modulo DEPTH.
//  Push into empty FIFO while IDLE: no pop same edge (data visible next cycle).
//  clr=1 at edge: FIFO emptied, state IDLE, bit_valid=0, bit_out=0; overrides push/pop
//   in same cycle (symbol offered that cycle is dropped; sym_ready stays per level=0).
//  Reset mid-symbol: partial symbol discarded, no bit emitted afterwards.
// STRUCTURE
//  qpsk_pkg: state encodings (ST_IDLE/ST_FIRST/ST_SECOND), SYM_W=2, I/Q bit index constants,
//   shared with the TX bit splitter so bit ordering is defined once.
//  Sub-module: qpsk_sym_fifo (synchronous FIFO, width SYM_W, depth FIFO_DEPTH, async
//   active-low reset, clr, push/pop, level, full/empty). Top holds FSM + shift register.
// TESTING
//  1 Single symbol 2'b10, bit_ready=1, I_FIRST=1 -> bits 1 then 0 on consecutive cycles,
//    first bit_valid two edges after push; fifo_level returns to 0.
//  2 Stream 2'b00,01,10,11 back-to-back, bit_ready=1 -> bits 0,0,0,1,1,0,1,1 with
//    bit_valid continuously high for 8 cycles, no bubbles.
//  3 Hold bit_ready=0, push 5 symbols (DEPTH=4) -> sym_ready drops after 4th FIFO write +
//    1 in serialiser, fifo_level=4; release -> all 10 bits in order, none lost/duplicated.
//  4 I_FIRST=0, symbol 2'b10 -> bits 0 then 1.
//  5 Assert clr while in SECOND with 3 buffered -> next cycle bit_valid=0, fifo_level=0,
//    symbol offered in clr cycle not emitted.
//  6 Pull rst_n low mid-FIRST (async, between edges) -> bit_valid=0 immediately,
//    fifo_level=0; after release, new symbol 2'b11 -> bits 1,1 only.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: symbol width, I/Q bit positions and serialiser
// state encodings. The TX bit splitter uses the same constants so bit
// ordering is defined in one place.
package qpsk_pkg;

    localparam int SYM_W = 2;
    localparam int I_IDX = 1;
    localparam int Q_IDX = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } ser_state_e;

    // Bit sent first from a symbol, given the I/Q ordering
    function automatic logic first_bit(input logic [SYM_W-1:0] sym, input bit i_first);
        return i_first ? sym[I_IDX] : sym[Q_IDX];
    endfunction

    // Bit sent second from a symbol, given the I/Q ordering
    function automatic logic second_bit(input logic [SYM_W-1:0] sym, input bit i_first);
        return i_first ? sym[Q_IDX] : sym[I_IDX];
    endfunction

endpackage

// File: rtl/qpsk_sym_fifo.sv
// Synchronous symbol FIFO. Power-of-two depth so the pointers wrap
// naturally. Push is refused when full and pop is ignored when empty;
// i_clr empties the FIFO and wins over a push or pop in the same cycle.
// o_level_next lets the owner register a ready flag without a bypass path.
module qpsk_sym_fifo
    import qpsk_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [SYM_W-1:0] i_wdata,
    input  logic             i_pop,
    output logic [SYM_W-1:0] o_rdata,
    output logic [LW-1:0]    o_level,
    output logic [LW-1:0]    o_level_next,
    output logic             o_full,
    output logic             o_empty
);

    logic [SYM_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [LW-1:0]    w_level_next;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_level_next = w_level_next;

    // Occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        w_level_next = r_level;
        if (i_clr) begin
            w_level_next = '0;
        end else if (w_push && !w_pop) begin
            w_level_next = r_level + LW'(1'b1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - LW'(1'b1);
        end else begin
            w_level_next = r_level;
        end
    end

    // Symbol storage write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !i_clr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Read/write pointers and occupancy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            r_level <= w_level_next;
        end
    end

endmodule

// File: rtl/qpsk_bit_combiner.sv
// QPSK receive bit combiner: buffers demapped {I,Q} symbols and
// re-serialises them, one bit per accepted handshake, in the configured
// I/Q order. A symbol is moved from the FIFO into the 2-bit shift register
// when the serialiser is idle, or when the second bit of the current
// symbol is accepted, which keeps the output at one bit per clock.
module qpsk_bit_combiner
    import qpsk_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    parameter  bit I_FIRST    = 1'b1,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic [LVL_W-1:0] fifo_level
);

    ser_state_e       r_state;
    logic [SYM_W-1:0] r_sh;
    logic             r_bit_out;
    logic             r_bit_valid;
    logic             r_sym_ready;

    logic [SYM_W-1:0] w_rdata;
    logic [LVL_W-1:0] w_level;
    logic [LVL_W-1:0] w_level_next;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Push only when advertised ready; pop when idle, or when the second bit leaves
    assign w_push = sym_valid && r_sym_ready && !w_full;
    assign w_pop  = !w_empty &&
                    ((r_state == ST_IDLE) || ((r_state == ST_SECOND) && bit_ready));

    qpsk_sym_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (clr),
        .i_push       (w_push),
        .i_wdata      (sym_in),
        .i_pop        (w_pop),
        .o_rdata      (w_rdata),
        .o_level      (w_level),
        .o_level_next (w_level_next),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // Registered ready: low in reset, then tracks "not full" with no same-cycle bypass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym_ready <= 1'b0;
        end else if (clr) begin
            r_sym_ready <= 1'b1;
        end else begin
            r_sym_ready <= (w_level_next != LVL_W'(FIFO_DEPTH));
        end
    end

    // Serialiser FSM with shift register and registered bit outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sh        <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
        end else if (clr) begin
            r_state     <= ST_IDLE;
            r_sh        <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_sh        <= w_rdata;
                        r_bit_out   <= first_bit(w_rdata, I_FIRST);
                        r_bit_valid <= 1'b1;
                        r_state     <= ST_FIRST;
                    end else begin
                        r_bit_out   <= 1'b0;
                        r_bit_valid <= 1'b0;
                    end
                end
                ST_FIRST: begin
                    if (bit_ready) begin
                        r_bit_out <= second_bit(r_sh, I_FIRST);
                        r_state   <= ST_SECOND;
                    end
                end
                ST_SECOND: begin
                    if (bit_ready) begin
                        if (w_pop) begin
                            r_sh        <= w_rdata;
                            r_bit_out   <= first_bit(w_rdata, I_FIRST);
                            r_bit_valid <= 1'b1;
                            r_state     <= ST_FIRST;
                        end else begin
                            r_bit_out   <= 1'b0;
                            r_bit_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_bit_out   <= 1'b0;
                    r_bit_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sym_ready  = r_sym_ready;
    assign bit_out    = r_bit_out;
    assign bit_valid  = r_bit_valid;
    assign fifo_level = w_level;

endmodule

// File: tb/tb_qpsk_bit_combiner.sv
// Bench for qpsk_bit_combiner. Two instances share all inputs: one sends
// the I bit first, the other the Q bit first. A queue-based reference model
// (symbol queue plus per-instance queue of bits still to be sent) predicts
// every output after every clock edge; directed sequences add checks of the
// accepted bitstreams against hand-written constants.
module tb_qpsk_bit_combiner;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic [1:0]    sym_in;
    logic          sym_valid;
    logic          bit_ready;
    logic          sym_ready_a, bit_out_a, bit_valid_a;
    logic          sym_ready_b, bit_out_b, bit_valid_b;
    logic [LW-1:0] level_a, level_b;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [1:0] mq[$];
    logic       sq_a[$];
    logic       sq_b[$];
    logic       rdy_m;

    // bits actually accepted from each DUT, and longest run of bit_valid
    int log_a[$];
    int log_b[$];
    int run_a;
    int max_run_a;

    always #5 clk = ~clk;

    qpsk_bit_combiner #(.FIFO_DEPTH(DEPTH), .I_FIRST(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(sym_ready_a), .bit_out(bit_out_a), .bit_valid(bit_valid_a),
        .bit_ready(bit_ready), .fifo_level(level_a)
    );

    qpsk_bit_combiner #(.FIFO_DEPTH(DEPTH), .I_FIRST(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(sym_ready_b), .bit_out(bit_out_b), .bit_valid(bit_valid_b),
        .bit_ready(bit_ready), .fifo_level(level_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sq_a.delete();
        sq_b.delete();
        rdy_m = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs held before the edge
    task automatic model_step();
        logic [1:0] s;
        logic       can_pop;
        logic       do_push;
        if (clr) begin
            mq.delete();
            sq_a.delete();
            sq_b.delete();
            rdy_m = 1'b1;
        end else begin
            if ((sq_a.size() != 0) && bit_ready) begin
                void'(sq_a.pop_front());
                void'(sq_b.pop_front());
            end
            can_pop = (sq_a.size() == 0) && (mq.size() != 0);
            do_push = sym_valid && rdy_m;
            if (can_pop) begin
                s = mq.pop_front();
                sq_a.push_back(s[1]);
                sq_a.push_back(s[0]);
                sq_b.push_back(s[0]);
                sq_b.push_back(s[1]);
            end
            if (do_push) begin
                mq.push_back(sym_in);
            end
            rdy_m = (mq.size() != DEPTH);
        end
    endtask

    task automatic check_outputs();
        logic bv, ea, eb;
        bv = (sq_a.size() != 0);
        ea = bv ? sq_a[0] : 1'b0;
        eb = bv ? sq_b[0] : 1'b0;
        chk("valid_a", {7'b0, bit_valid_a}, {7'b0, bv});
        chk("valid_b", {7'b0, bit_valid_b}, {7'b0, bv});
        chk("bit_a",   {7'b0, bit_out_a},   {7'b0, ea});
        chk("bit_b",   {7'b0, bit_out_b},   {7'b0, eb});
        chk("ready_a", {7'b0, sym_ready_a}, {7'b0, rdy_m});
        chk("ready_b", {7'b0, sym_ready_b}, {7'b0, rdy_m});
        chk("level_a", 8'(level_a), 8'(mq.size()));
        chk("level_b", 8'(level_b), 8'(mq.size()));
    endtask

    // Called at a negedge with inputs already set: log handshakes, clock, model, check
    task automatic cycle();
        if (bit_valid_a && bit_ready) log_a.push_back(int'(bit_out_a));
        if (bit_valid_b && bit_ready) log_b.push_back(int'(bit_out_b));
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
        check_outputs();
        if (bit_valid_a) run_a++;
        else             run_a = 0;
        if (run_a > max_run_a) max_run_a = run_a;
    endtask

    task automatic push_sym(input logic [1:0] s);
        sym_in    = s;
        sym_valid = 1'b1;
        cycle();
        sym_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        sym_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Compare an accepted-bit log against n expected bits listed MSB first
    task automatic check_log(input string tag, input int q[$], input logic [15:0] exp, input int n);
        chk({tag, "_len"}, 8'(q.size()), 8'(n));
        for (int i = 0; i < n && i < q.size(); i++) begin
            chk(tag, 8'(q[i]), {7'b0, exp[n-1-i]});
        end
    endtask

    task automatic clear_logs();
        log_a.delete();
        log_b.delete();
        run_a     = 0;
        max_run_a = 0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; sym_in = 2'b00; sym_valid = 1'b0; bit_ready = 1'b1;
        run_a = 0; max_run_a = 0;
        model_reset();
        @(negedge clk);
        check_outputs();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("ready_after_reset", {7'b0, sym_ready_a}, 8'd1);

        // 1: single symbol 10, latency and order
        clear_logs();
        push_sym(2'b10);
        chk("t1_no_bypass", {7'b0, bit_valid_a}, 8'd0);
        cycle();
        chk("t1_first_valid", {7'b0, bit_valid_a}, 8'd1);
        chk("t1_first_bit",   {7'b0, bit_out_a},   8'd1);
        cycle();
        chk("t1_second_bit",  {7'b0, bit_out_a},   8'd0);
        idle_cycles(3);
        chk("t1_level", 8'(level_a), 8'd0);
        check_log("t1_bits_a", log_a, 16'b10, 2);
        // 4: same symbol with Q first
        check_log("t4_bits_b", log_b, 16'b01, 2);

        // 2: back-to-back stream, no bubbles
        clear_logs();
        push_sym(2'b00); push_sym(2'b01); push_sym(2'b10); push_sym(2'b11);
        idle_cycles(8);
        check_log("t2_bits_a", log_a, 16'b00011011, 8);
        check_log("t2_bits_b", log_b, 16'b00100111, 8);
        chk("t2_run", 8'(max_run_a), 8'd8);

        // 3: stall sink, fill FIFO, then release
        clear_logs();
        bit_ready = 1'b0;
        push_sym(2'b01); push_sym(2'b10); push_sym(2'b11); push_sym(2'b00); push_sym(2'b10);
        chk("t3_level_full", 8'(level_a), 8'd4);
        chk("t3_ready_low",  {7'b0, sym_ready_a}, 8'd0);
        push_sym(2'b11);
        chk("t3_refused", 8'(level_a), 8'd4);
        bit_ready = 1'b1;
        idle_cycles(12);
        check_log("t3_bits_a", log_a, 16'b0110110010, 10);
        check_log("t3_bits_b", log_b, 16'b1001110001, 10);

        // 5: clr in SECOND with three buffered
        bit_ready = 1'b0;
        push_sym(2'b10); push_sym(2'b01); push_sym(2'b11); push_sym(2'b01);
        bit_ready = 1'b1;
        cycle();
        bit_ready = 1'b0;
        chk("t5_level_pre", 8'(level_a), 8'd3);
        clr = 1'b1; sym_valid = 1'b1; sym_in = 2'b11;
        cycle();
        clr = 1'b0; sym_valid = 1'b0;
        chk("t5_valid", {7'b0, bit_valid_a}, 8'd0);
        chk("t5_level", 8'(level_a), 8'd0);
        clear_logs();
        bit_ready = 1'b1;
        idle_cycles(5);
        chk("t5_nothing_out", 8'(log_a.size()), 8'd0);

        // 6: async reset mid-FIRST, then symbol 11
        bit_ready = 1'b0;
        push_sym(2'b01);
        cycle();
        chk("t6_in_first", {7'b0, bit_valid_a}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        cycle();
        rst_n = 1'b1;
        cycle();
        clear_logs();
        bit_ready = 1'b1;
        push_sym(2'b11);
        idle_cycles(5);
        check_log("t6_bits_a", log_a, 16'b11, 2);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            sym_in    = 2'($urandom_range(0, 3));
            sym_valid = ($urandom_range(0, 3) != 0);
            bit_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 49) == 0);
            cycle();
        end
        clr = 1'b0; sym_valid = 1'b0; bit_ready = 1'b1;
        idle_cycles(12);
        chk("final_level", 8'(level_a), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
